// File: rtl/backend_ap_dispatcher.sv
// -----------------------------------------------------------------------------
// backend_ap_dispatcher
//
// Purpose:
//   Buffers frontend commands in a DEPTH-entry queue and issues them one at a
//   time to the rank slice controller. This block also decides the
//   auto-precharge flag for each command. A lookahead check clears auto-precharge
//   only when the next queued command targets the same bank and row as the
//   head. A lone head entry may wait up to WAIT_CYCLES cycles for a partner
//   before it is issued with auto-precharge set.
//
// Handshakes (both channels):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. The producer keeps valid and its payload stable until that edge.
//   Ready may be driven regardless of valid.
//
// Ports:
//   clk, power_on_rst        clock, asynchronous active-high reset
//   i_cmd_*  / o_cmd_ready   frontend command channel (push into queue)
//   o_issue_* / i_issue_ready command channel to the slice controller (pop)
//   o_fifo_level             current queue occupancy
//   o_hit_count, o_ap_count  saturating counts of issued ap=0 / ap=1 commands
//   o_dbg_state              FSM state (0 IDLE, 1 WAIT, 2 ISSUE)
// -----------------------------------------------------------------------------
module backend_ap_dispatcher #(
    parameter int ROW_BITS    = 14,
    parameter int COL_BITS    = 10,
    parameter int BANK_BITS   = 3,
    parameter int DATA_BITS   = 128,
    parameter int DEPTH       = 4,
    parameter int WAIT_CYCLES = 4,
    parameter int CNT_BITS    = 16
) (
    input  logic                     clk,
    input  logic                     power_on_rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_op,
    input  logic [BANK_BITS-1:0]     i_cmd_bank,
    input  logic [ROW_BITS-1:0]      i_cmd_row,
    input  logic [COL_BITS-1:0]      i_cmd_col,
    input  logic [DATA_BITS-1:0]     i_cmd_wdata,
    output logic                     o_issue_valid,
    input  logic                     i_issue_ready,
    output logic                     o_issue_rw,
    output logic [BANK_BITS-1:0]     o_issue_bank,
    output logic [ROW_BITS-1:0]      o_issue_row,
    output logic [COL_BITS-1:0]      o_issue_col,
    output logic                     o_issue_ap,
    output logic [DATA_BITS-1:0]     o_issue_wdata,
    output logic [$clog2(DEPTH):0]   o_fifo_level,
    output logic [CNT_BITS-1:0]      o_hit_count,
    output logic [CNT_BITS-1:0]      o_ap_count,
    output logic [1:0]               o_dbg_state
);

    localparam int PTR_BITS  = $clog2(DEPTH);
    localparam int LVL_BITS  = PTR_BITS + 1;
    localparam int TMR_BITS  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int WAIT_LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    localparam logic [LVL_BITS-1:0] LVL_FULL = LVL_BITS'(DEPTH);
    localparam logic [LVL_BITS-1:0] LVL_TWO  = LVL_BITS'(2);
    localparam logic [LVL_BITS-1:0] LVL_ZERO = '0;
    localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(WAIT_LAST);
    localparam bit                  NO_WAIT  = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    // Queue storage; no reset needed, occupancy is tracked by count_q.
    logic                 rw_mem    [DEPTH];
    logic [BANK_BITS-1:0] bank_mem  [DEPTH];
    logic [ROW_BITS-1:0]  row_mem   [DEPTH];
    logic [COL_BITS-1:0]  col_mem   [DEPTH];
    logic [DATA_BITS-1:0] wdata_mem [DEPTH];

    logic [PTR_BITS-1:0]  head_q, head_d, tail_q, tail_d, head_next;
    logic [LVL_BITS-1:0]  count_q, count_d;
    state_e               state_q;
    logic [TMR_BITS-1:0]  timer_q;
    logic                 issue_valid_q, issue_ap_q;
    logic [CNT_BITS-1:0]  hit_cnt_q, ap_cnt_q;

    logic                 push, pop, has_pair, pair_hit, ap_calc;

    // ---------------------------------------------------------------------
    // Queue control
    // ---------------------------------------------------------------------
    always_comb begin
        push      = i_cmd_valid && o_cmd_ready;
        pop       = issue_valid_q && i_issue_ready;
        head_next = head_q + PTR_BITS'(1);
        head_d    = pop  ? head_next : head_q;
        tail_d    = push ? (tail_q + PTR_BITS'(1)) : tail_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LVL_BITS'(1);
            2'b01:   count_d = count_q - LVL_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    // Lookahead: entry[head+1] is only meaningful when two entries are held.
    always_comb begin
        has_pair = (count_q >= LVL_TWO);
        pair_hit = has_pair
                   && (bank_mem[head_next] == bank_mem[head_q])
                   && (row_mem[head_next]  == row_mem[head_q]);
        ap_calc  = !pair_hit;
    end

    always_ff @(posedge clk or posedge power_on_rst) begin
        if (power_on_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rw_mem[tail_q]    <= i_cmd_op;
            bank_mem[tail_q]  <= i_cmd_bank;
            row_mem[tail_q]   <= i_cmd_row;
            col_mem[tail_q]   <= i_cmd_col;
            wdata_mem[tail_q] <= i_cmd_wdata;
        end
    end

    // ---------------------------------------------------------------------
    // Issue FSM. ap is latched on entry to ISSUE so that pushes arriving while
    // the command is presented cannot change it.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge power_on_rst) begin
        if (power_on_rst) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_ap_q    <= 1'b0;
            hit_cnt_q     <= '0;
            ap_cnt_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q != LVL_ZERO) begin
                        if (has_pair || NO_WAIT) begin
                            state_q       <= ST_ISSUE;
                            issue_valid_q <= 1'b1;
                            issue_ap_q    <= ap_calc;
                        end else begin
                            state_q <= ST_WAIT;
                            timer_q <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    timer_q <= timer_q + TMR_BITS'(1);
                    if (has_pair || (timer_q == TMR_LAST)) begin
                        state_q       <= ST_ISSUE;
                        issue_valid_q <= 1'b1;
                        issue_ap_q    <= ap_calc;
                    end
                end
                ST_ISSUE: begin
                    // Returning to IDLE leaves one bubble cycle between issues.
                    if (i_issue_ready) begin
                        state_q       <= ST_IDLE;
                        issue_valid_q <= 1'b0;
                        if (issue_ap_q) begin
                            if (ap_cnt_q != '1) ap_cnt_q <= ap_cnt_q + CNT_BITS'(1);
                        end else begin
                            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_BITS'(1);
                        end
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    issue_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign o_cmd_ready   = (count_q != LVL_FULL);
    assign o_issue_valid = issue_valid_q;
    assign o_issue_ap    = issue_ap_q;
    assign o_issue_rw    = rw_mem[head_q];
    assign o_issue_bank  = bank_mem[head_q];
    assign o_issue_row   = row_mem[head_q];
    assign o_issue_col   = col_mem[head_q];
    assign o_issue_wdata = wdata_mem[head_q];
    assign o_fifo_level  = count_q;
    assign o_hit_count   = hit_cnt_q;
    assign o_ap_count    = ap_cnt_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_backend_ap_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_backend_ap_dispatcher
//
// Drives the dispatcher with directed scenarios and a randomized phase. A
// queue-based reference model predicts every output cycle by cycle. A second
// instance built with WAIT_CYCLES = 0 covers the no-wait path.
// -----------------------------------------------------------------------------
module tb_backend_ap_dispatcher;

    localparam int ROW_BITS  = 14;
    localparam int COL_BITS  = 10;
    localparam int BANK_BITS = 3;
    localparam int DATA_BITS = 128;
    localparam int DEPTH     = 4;
    localparam int WAIT_CYC  = 4;
    localparam int CNT_BITS  = 16;
    localparam int LVL_BITS  = $clog2(DEPTH) + 1;

    // Packed command layout: {rw, bank, row, col, wdata}
    localparam int CMD_W  = 1 + BANK_BITS + ROW_BITS + COL_BITS + DATA_BITS;
    localparam int COL_LO = DATA_BITS;
    localparam int ROW_LO = COL_LO + COL_BITS;
    localparam int BNK_LO = ROW_LO + ROW_BITS;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clk = 1'b0;
    logic power_on_rst;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // DUT (WAIT_CYCLES = 4)
    // ---------------------------------------------------------------------
    logic                 i_cmd_valid, o_cmd_ready, i_cmd_op;
    logic [BANK_BITS-1:0] i_cmd_bank;
    logic [ROW_BITS-1:0]  i_cmd_row;
    logic [COL_BITS-1:0]  i_cmd_col;
    logic [DATA_BITS-1:0] i_cmd_wdata;
    logic                 o_issue_valid, i_issue_ready, o_issue_rw, o_issue_ap;
    logic [BANK_BITS-1:0] o_issue_bank;
    logic [ROW_BITS-1:0]  o_issue_row;
    logic [COL_BITS-1:0]  o_issue_col;
    logic [DATA_BITS-1:0] o_issue_wdata;
    logic [LVL_BITS-1:0]  o_fifo_level;
    logic [CNT_BITS-1:0]  o_hit_count, o_ap_count;
    logic [1:0]           o_dbg_state;

    backend_ap_dispatcher #(
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .BANK_BITS(BANK_BITS),
        .DATA_BITS(DATA_BITS), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYC),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .clk(clk), .power_on_rst(power_on_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_bank(i_cmd_bank), .i_cmd_row(i_cmd_row),
        .i_cmd_col(i_cmd_col), .i_cmd_wdata(i_cmd_wdata),
        .o_issue_valid(o_issue_valid), .i_issue_ready(i_issue_ready),
        .o_issue_rw(o_issue_rw), .o_issue_bank(o_issue_bank),
        .o_issue_row(o_issue_row), .o_issue_col(o_issue_col),
        .o_issue_ap(o_issue_ap), .o_issue_wdata(o_issue_wdata),
        .o_fifo_level(o_fifo_level), .o_hit_count(o_hit_count),
        .o_ap_count(o_ap_count), .o_dbg_state(o_dbg_state)
    );

    // ---------------------------------------------------------------------
    // Second instance, WAIT_CYCLES = 0
    // ---------------------------------------------------------------------
    logic                 z_cmd_valid, z_cmd_ready, z_issue_valid, z_issue_ready;
    logic                 z_issue_rw, z_issue_ap;
    logic [BANK_BITS-1:0] z_issue_bank;
    logic [ROW_BITS-1:0]  z_issue_row;
    logic [COL_BITS-1:0]  z_issue_col;
    logic [DATA_BITS-1:0] z_issue_wdata;
    logic [LVL_BITS-1:0]  z_fifo_level;
    logic [CNT_BITS-1:0]  z_hit_count, z_ap_count;
    logic [1:0]           z_dbg_state;

    backend_ap_dispatcher #(
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .BANK_BITS(BANK_BITS),
        .DATA_BITS(DATA_BITS), .DEPTH(DEPTH), .WAIT_CYCLES(0),
        .CNT_BITS(CNT_BITS)
    ) dut_nowait (
        .clk(clk), .power_on_rst(power_on_rst),
        .i_cmd_valid(z_cmd_valid), .o_cmd_ready(z_cmd_ready),
        .i_cmd_op(1'b1), .i_cmd_bank(3'd6), .i_cmd_row(14'd77),
        .i_cmd_col(10'd5), .i_cmd_wdata('0),
        .o_issue_valid(z_issue_valid), .i_issue_ready(z_issue_ready),
        .o_issue_rw(z_issue_rw), .o_issue_bank(z_issue_bank),
        .o_issue_row(z_issue_row), .o_issue_col(z_issue_col),
        .o_issue_ap(z_issue_ap), .o_issue_wdata(z_issue_wdata),
        .o_fifo_level(z_fifo_level), .o_hit_count(z_hit_count),
        .o_ap_count(z_ap_count), .o_dbg_state(z_dbg_state)
    );

    // ---------------------------------------------------------------------
    // Scoreboard counters and check task
    // ---------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [255:0] got,
                            input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: a queue of pending commands plus a description of
    // what the dispatcher is doing with the head (presenting it, or counting
    // down the wait for a lookahead partner).
    // ---------------------------------------------------------------------
    logic [CMD_W-1:0]    exp_q[$];
    bit                  m_valid, m_ap, m_waiting;
    int                  m_wait_left;
    logic [CNT_BITS-1:0] m_hit, m_apc;
    int                  m_sz;
    bit                  m_hs, m_pu;

    function automatic bit same_page(input logic [CMD_W-1:0] a, input logic [CMD_W-1:0] b);
        return (a[BNK_LO +: BANK_BITS] == b[BNK_LO +: BANK_BITS]) &&
               (a[ROW_LO +: ROW_BITS] == b[ROW_LO +: ROW_BITS]);
    endfunction

    always @(posedge clk or posedge power_on_rst) begin
        if (power_on_rst) begin
            exp_q.delete();
            m_valid = 0; m_ap = 0; m_waiting = 0; m_wait_left = 0;
            m_hit = '0; m_apc = '0;
        end else begin
            m_sz = exp_q.size();
            m_hs = m_valid && i_issue_ready;
            m_pu = i_cmd_valid && (m_sz != DEPTH);
            if (m_valid) begin
                if (m_hs) begin
                    void'(exp_q.pop_front());
                    m_valid = 0;
                    if (m_ap) begin
                        if (m_apc != '1) m_apc = m_apc + 1'b1;
                    end else begin
                        if (m_hit != '1) m_hit = m_hit + 1'b1;
                    end
                end
            end else if (m_waiting && (m_sz < 2) && (m_wait_left > 1)) begin
                m_wait_left = m_wait_left - 1;
            end else if (m_waiting || m_sz >= 2 || (m_sz == 1 && WAIT_CYC == 0)) begin
                m_waiting = 0;
                m_valid   = 1;
                m_ap      = !(m_sz >= 2 && same_page(exp_q[0], exp_q[1]));
            end else if (m_sz == 1) begin
                m_waiting   = 1;
                m_wait_left = WAIT_CYC;
            end
            if (m_pu)
                exp_q.push_back({i_cmd_op, i_cmd_bank, i_cmd_row, i_cmd_col, i_cmd_wdata});
        end
    end

    // Per-cycle comparison of every output against the model.
    bit mon_en = 0;
    always @(negedge clk) begin
        if (mon_en && !power_on_rst) begin
            check_eq("issue_valid", o_issue_valid, m_valid);
            check_eq("fifo_level", o_fifo_level, exp_q.size());
            check_eq("cmd_ready", o_cmd_ready, exp_q.size() != DEPTH);
            check_eq("hit_count", o_hit_count, m_hit);
            check_eq("ap_count", o_ap_count, m_apc);
            if (m_valid) begin
                check_eq("issue_fields",
                         {o_issue_rw, o_issue_bank, o_issue_row, o_issue_col, o_issue_wdata},
                         exp_q[0]);
                check_eq("issue_ap", o_issue_ap, m_ap);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic rw, input int bank, input int row, input int col);
        i_cmd_op    = rw;
        i_cmd_bank  = BANK_BITS'(bank);
        i_cmd_row   = ROW_BITS'(row);
        i_cmd_col   = COL_BITS'(col);
        i_cmd_wdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic push_cmd(input logic rw, input int bank, input int row, input int col);
        set_cmd(rw, bank, row, col);
        i_cmd_valid = 1'b1;
        step();
        i_cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        power_on_rst = 1'b1;
        repeat (2) @(negedge clk);
        power_on_rst = 1'b0;
    endtask

    task automatic wait_issue(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (o_issue_valid) break;
            step();
        end
        check_eq(tag, o_issue_valid, 1'b1);
    endtask

    task automatic drain(input int cycles);
        i_issue_ready = 1'b1;
        repeat (cycles) step();
        i_issue_ready = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        i_cmd_valid = 0; i_issue_ready = 0;
        set_cmd(0, 0, 0, 0);
        z_cmd_valid = 0; z_issue_ready = 0;
        power_on_rst = 1'b0;
        @(negedge clk);
        do_reset();
        mon_en = 1;

        // Reset state
        check_eq("rst_valid", o_issue_valid, 1'b0);
        check_eq("rst_ap", o_issue_ap, 1'b0);
        check_eq("rst_level", o_fifo_level, 0);
        check_eq("rst_ready", o_cmd_ready, 1'b1);

        // Same bank/row pair then a lone entry that times out
        i_issue_ready = 1'b1;
        push_cmd(1, 2, 5, 0);
        push_cmd(1, 2, 5, 8);
        wait_issue("pair_issue_seen", 10);
        check_eq("pair_first_ap", o_issue_ap, 1'b0);
        repeat (14) step();
        check_eq("pair_hit_total", o_hit_count, 1);
        check_eq("pair_ap_total", o_ap_count, 1);
        check_eq("pair_drained", o_fifo_level, 0);

        // Reset while presenting a command with three queued
        i_issue_ready = 1'b0;
        push_cmd(0, 1, 1, 1);
        push_cmd(0, 1, 1, 2);
        push_cmd(0, 3, 1, 3);
        wait_issue("pre_rst_issue_seen", 10);
        #2 power_on_rst = 1'b1;
        #1;
        check_eq("midrst_valid", o_issue_valid, 1'b0);
        check_eq("midrst_level", o_fifo_level, 0);
        check_eq("midrst_hit", o_hit_count, 0);
        check_eq("midrst_apc", o_ap_count, 0);
        @(negedge clk);
        power_on_rst = 1'b0;
        step();
        check_eq("post_rst_ready", o_cmd_ready, 1'b1);

        // Bank mismatch, then row mismatch
        push_cmd(0, 1, 3, 0);
        push_cmd(0, 4, 3, 0);
        wait_issue("bank_mm_issue_seen", 10);
        check_eq("bank_mismatch_ap", o_issue_ap, 1'b1);
        drain(16);
        push_cmd(1, 5, 3, 0);
        push_cmd(1, 5, 4, 0);
        wait_issue("row_mm_issue_seen", 10);
        check_eq("row_mismatch_ap", o_issue_ap, 1'b1);
        drain(16);

        // Stall with full queue, then a single pop
        i_issue_ready = 1'b0;
        i_cmd_valid   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_cmd(k[0], 2, 9, k * 8);
            step();
        end
        i_cmd_valid = 1'b0;
        check_eq("full_level", o_fifo_level, 4);
        check_eq("full_ready", o_cmd_ready, 1'b0);
        repeat (3) step();
        check_eq("stall_valid", o_issue_valid, 1'b1);
        i_issue_ready = 1'b1;
        step();
        i_issue_ready = 1'b0;
        check_eq("one_pop_level", o_fifo_level, 3);
        check_eq("one_pop_ready", o_cmd_ready, 1'b1);
        drain(20);

        // Lone entry in WAIT gains a partner before the timeout
        push_cmd(0, 6, 11, 0);
        step();
        step();
        push_cmd(0, 6, 11, 16);
        check_eq("late_partner_pending", o_issue_valid, 1'b0);
        step();
        check_eq("late_partner_valid", o_issue_valid, 1'b1);
        check_eq("late_partner_ap", o_issue_ap, 1'b0);
        drain(16);

        // Randomized traffic on a small bank/row space to provoke hits
        for (int c = 0; c < 3000; c++) begin
            set_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1023));
            i_cmd_valid   = ($urandom_range(0, 99) < 45);
            i_issue_ready = ($urandom_range(0, 99) < 60);
            step();
        end
        i_cmd_valid = 1'b0;
        drain(40);
        check_eq("final_drained", o_fifo_level, 0);

        // WAIT_CYCLES = 0: issued two cycles after the push handshake
        z_cmd_valid = 1'b1;
        step();
        z_cmd_valid = 1'b0;
        check_eq("nowait_level", z_fifo_level, 1);
        check_eq("nowait_not_yet", z_issue_valid, 1'b0);
        step();
        check_eq("nowait_valid", z_issue_valid, 1'b1);
        check_eq("nowait_ap", z_issue_ap, 1'b1);
        check_eq("nowait_bank", z_issue_bank, 3'd6);
        z_issue_ready = 1'b1;
        step();
        z_issue_ready = 1'b0;
        check_eq("nowait_apc", z_ap_count, 1);

        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
